decode_fwd: RTL and testbench
=============================

# decode_fwd

Pipelined decode / register-read stage for the Y-86 processor, the consumer side of `write_back`. It reads operands from the `regis0`..`regis14` outputs of `write_back`, resolves data hazards against in-flight results from execute, memory and writeback, and loads the D→E pipeline register. It also detects load/use hazards, stalls fetch/decode, and injects bubbles into execute.

## Interface
- No parameters.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: synchronous reset, active-low.
- `D_icode`, `D_ifun`, `D_ra`, `D_rb` input 4 each: decoded fields from the D register.
- `D_valC`, `D_valP` input 64 each: constant and next PC.
- `flush` input 1: branch mispredict; execute receives a bubble next cycle.
- `regis0`..`regis14` input 64 each: architectural registers from `write_back`.
- `e_dstE` input 4, `e_valE` input 64: execute result, with cmov condition already applied.
- `M_dstE`, `M_dstM` input 4; `M_valE`, `m_valM` input 64: memory stage results.
- `W_dstE`, `W_dstM` input 4; `W_valE`, `W_valM` input 64: writeback stage results.
- `stall_D` output 1: hold F and D this cycle (combinational).
- `E_icode`, `E_ifun` output 4 each: registered.
- `E_valC`, `E_valA`, `E_valB` output 64 each: registered.
- `E_dstE`, `E_dstM`, `E_srcA`, `E_srcB` output 4 each: registered.

## Operation
- Register ID 4'hF means "none". Reading ID F returns 0. Reading ID 4 means `%rsp`.
- srcA:
  - rA for icodes 2, 4, 6, A.
  - 4 for icodes 9, B.
  - F otherwise.
- srcB:
  - rB for icodes 4, 5, 6.
  - 4 for icodes 8, 9, A, B.
  - F otherwise.
- dstE:
  - rB for icodes 2, 3, 6.
  - 4 for icodes 8, 9, A, B.
  - F otherwise.
- dstM:
  - rA for icodes 5, B.
  - F otherwise.
- valA selection, first match wins:
  1. `D_valP` for icode 7 or 8.
  2. `e_valE` if srcA = `e_dstE`.
  3. `m_valM` if srcA = `M_dstM`.
  4. `M_valE` if srcA = `M_dstE`.
  5. `W_valM` if srcA = `W_dstM`.
  6. `W_valE` if srcA = `W_dstE`.
  7. Register file.
- valB uses the same chain without the `D_valP` step.
- A match against F never forwards.
- Load/use hazard: registered `E_icode` is 5 or B, `E_dstM` ≠ F, and `E_dstM` equals srcA or srcB.
- `stall_D` = hazard & ~`flush`.
- E bubble = hazard | `flush`. A bubble loads icode 1 (nop), ifun 0, valC/valA/valB 0, and all four IDs F.
- Unknown icodes (above B) decode with every ID set to F and pass through unchanged.

## Timing
- Decode, forwarding and hazard detection are combinational from D and stage inputs. The E register updates on the rising edge, so latency is one cycle.
- Reset (`rst_n` = 0 at an edge) overrides everything and loads the bubble values: `E_icode`=1, all other data 0, all IDs F. `stall_D` is 0 while E holds the reset bubble.
- Reset in the middle of a stall clears E to the bubble. The stall condition then disappears next cycle.
- A load/use stall lasts exactly one cycle. The bubble clears `E_dstM`, so the hazard cannot persist.
- `flush` together with a hazard: E gets a bubble and `stall_D` = 0, so the mispredicted instruction is dropped.
- When several stages write the same register, the youngest stage wins (e > M > W). `m_valM` beats `M_valE` when `M_dstM` = `M_dstE`.
- `e_dstE` = F (cmov not taken) disables that forwarding source.

## Configuration
- `DECODE_FWD_EN` defined: full forwarding as described above. Only load/use hazards stall.
- `DECODE_FWD_EN` undefined:
  - Operands come only from `regis*`, except `D_valP` for icodes 7 and 8.
  - Hazard = a non-F srcA/srcB matches any of registered `E_dstE`/`E_dstM`, `M_dstE`, `M_dstM`, `W_dstE`, `W_dstM`.
  - Each hazard cycle stalls D and bubbles E, for up to 3 cycles per dependency.

## Test plan
- Reset: hold `rst_n`=0 for 2 edges with nonzero inputs → `E_icode`=1, `E_valA`=`E_valB`=0, all IDs F, `stall_D`=0.
- No hazard: `regis3`=5, `regis4`=9, D = `addq %rbx,%rsp` (60 34) → next cycle `E_valA`=5, `E_valB`=9, `E_dstE`=4, `E_dstM`=F.
- Priority: srcA=3 with `e_dstE`=3/`e_valE`=11, `M_dstE`=3/`M_valE`=22, `W_dstE`=3/`W_valE`=33 → `E_valA`=11. Then `e_dstE`=F → 22.
- Load/use: `mrmovq` into %rax (icode 5, rA=0) enters E, D = `addq %rax,%rbx` → `stall_D`=1 for one cycle and E becomes a nop. The following cycle `E_valA` = `m_valM` with `M_dstM`=0.
- Flush with load/use hazard: `flush`=1 in the hazard cycle → `stall_D`=0 and `E_icode`=1 next cycle.
- `call` (icode 8, `D_valP`=0x40, `regis4`=0x100) → `E_valA`=0x40, `E_valB`=0x100, `E_dstE`=4. With `DECODE_FWD_EN` undefined, the addq dependency on the previous cycle's `W_dstE` stalls for 1 cycle.

Source files
------------

// File: rtl/decode_fwd.sv
// Y-86 decode / register-read stage: operand decode, forwarding, load/use stall, D->E register.
// Define DECODE_FWD_EN for full forwarding; otherwise operands come from the register file only
// and any in-flight dependency stalls.
module decode_fwd (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  D_icode,
  input  logic [3:0]  D_ifun,
  input  logic [3:0]  D_ra,
  input  logic [3:0]  D_rb,
  input  logic [63:0] D_valC,
  input  logic [63:0] D_valP,
  input  logic        flush,
  input  logic [63:0] regis0,
  input  logic [63:0] regis1,
  input  logic [63:0] regis2,
  input  logic [63:0] regis3,
  input  logic [63:0] regis4,
  input  logic [63:0] regis5,
  input  logic [63:0] regis6,
  input  logic [63:0] regis7,
  input  logic [63:0] regis8,
  input  logic [63:0] regis9,
  input  logic [63:0] regis10,
  input  logic [63:0] regis11,
  input  logic [63:0] regis12,
  input  logic [63:0] regis13,
  input  logic [63:0] regis14,
  input  logic [3:0]  e_dstE,
  input  logic [63:0] e_valE,
  input  logic [3:0]  M_dstE,
  input  logic [3:0]  M_dstM,
  input  logic [63:0] M_valE,
  input  logic [63:0] m_valM,
  input  logic [3:0]  W_dstE,
  input  logic [3:0]  W_dstM,
  input  logic [63:0] W_valE,
  input  logic [63:0] W_valM,
  output logic        stall_D,
  output logic [3:0]  E_icode,
  output logic [3:0]  E_ifun,
  output logic [63:0] E_valC,
  output logic [63:0] E_valA,
  output logic [63:0] E_valB,
  output logic [3:0]  E_dstE,
  output logic [3:0]  E_dstM,
  output logic [3:0]  E_srcA,
  output logic [3:0]  E_srcB
);

  localparam logic [3:0] RegNone = 4'hF;
  localparam logic [3:0] RegRsp  = 4'h4;

  localparam logic [3:0] INop   = 4'h1;
  localparam logic [3:0] IRrmov = 4'h2;
  localparam logic [3:0] IIrmov = 4'h3;
  localparam logic [3:0] IRmmov = 4'h4;
  localparam logic [3:0] IMrmov = 4'h5;
  localparam logic [3:0] IOpq   = 4'h6;
  localparam logic [3:0] IJxx   = 4'h7;
  localparam logic [3:0] ICall  = 4'h8;
  localparam logic [3:0] IRet   = 4'h9;
  localparam logic [3:0] IPush  = 4'hA;
  localparam logic [3:0] IPop   = 4'hB;

  logic [63:0] rf [15];
  logic [3:0]  src_a, src_b, dst_e, dst_m;
  logic [63:0] rd_a, rd_b, val_a, val_b;
  logic        hazard, bubble;

  assign rf[0]  = regis0;
  assign rf[1]  = regis1;
  assign rf[2]  = regis2;
  assign rf[3]  = regis3;
  assign rf[4]  = regis4;
  assign rf[5]  = regis5;
  assign rf[6]  = regis6;
  assign rf[7]  = regis7;
  assign rf[8]  = regis8;
  assign rf[9]  = regis9;
  assign rf[10] = regis10;
  assign rf[11] = regis11;
  assign rf[12] = regis12;
  assign rf[13] = regis13;
  assign rf[14] = regis14;

  always_comb begin
    src_a = RegNone;
    src_b = RegNone;
    dst_e = RegNone;
    dst_m = RegNone;
    case (D_icode)
      IRrmov: begin src_a = D_ra;   dst_e = D_rb; end
      IIrmov: begin dst_e = D_rb; end
      IRmmov: begin src_a = D_ra;   src_b = D_rb; end
      IMrmov: begin src_b = D_rb;   dst_m = D_ra; end
      IOpq:   begin src_a = D_ra;   src_b = D_rb;   dst_e = D_rb; end
      ICall:  begin src_b = RegRsp; dst_e = RegRsp; end
      IRet:   begin src_a = RegRsp; src_b = RegRsp; dst_e = RegRsp; end
      IPush:  begin src_a = D_ra;   src_b = RegRsp; dst_e = RegRsp; end
      IPop:   begin src_a = RegRsp; src_b = RegRsp; dst_e = RegRsp; dst_m = D_ra; end
      default: ;
    endcase
  end

  always_comb begin
    rd_a = '0;
    rd_b = '0;
    if (src_a != RegNone) rd_a = rf[src_a];
    if (src_b != RegNone) rd_b = rf[src_b];
  end

`ifdef DECODE_FWD_EN
  // Youngest stage first; src never equals RegNone here, so a dst of F cannot match.
  function automatic logic [63:0] fwd(input logic [3:0] src, input logic [63:0] rd);
    if (src == RegNone)     return rd;
    else if (src == e_dstE) return e_valE;
    else if (src == M_dstM) return m_valM;
    else if (src == M_dstE) return M_valE;
    else if (src == W_dstM) return W_valM;
    else if (src == W_dstE) return W_valE;
    else                    return rd;
  endfunction

  always_comb begin
    val_a  = (D_icode == IJxx || D_icode == ICall) ? D_valP : fwd(src_a, rd_a);
    val_b  = fwd(src_b, rd_b);
    hazard = (E_icode == IMrmov || E_icode == IPop) && (E_dstM != RegNone) &&
             (E_dstM == src_a || E_dstM == src_b);
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{e_dstE, e_valE, M_valE, m_valM, W_valE, W_valM};

  function automatic logic pending(input logic [3:0] src);
    return (src != RegNone) &&
           (src == E_dstE || src == E_dstM || src == M_dstE ||
            src == M_dstM || src == W_dstE || src == W_dstM);
  endfunction

  always_comb begin
    val_a  = (D_icode == IJxx || D_icode == ICall) ? D_valP : rd_a;
    val_b  = rd_b;
    hazard = pending(src_a) || pending(src_b);
  end
`endif

  assign stall_D = hazard & ~flush;
  assign bubble  = hazard | flush;

  always_ff @(posedge clk) begin
    if (!rst_n || bubble) begin
      E_icode <= INop;
      E_ifun  <= '0;
      E_valC  <= '0;
      E_valA  <= '0;
      E_valB  <= '0;
      E_dstE  <= RegNone;
      E_dstM  <= RegNone;
      E_srcA  <= RegNone;
      E_srcB  <= RegNone;
    end else begin
      E_icode <= D_icode;
      E_ifun  <= D_ifun;
      E_valC  <= D_valC;
      E_valA  <= val_a;
      E_valB  <= val_b;
      E_dstE  <= dst_e;
      E_dstM  <= dst_m;
      E_srcA  <= src_a;
      E_srcB  <= src_b;
    end
  end

endmodule

// File: tb/tb_decode_fwd.sv
// Directed and randomized bench for decode_fwd against a table-driven reference model.
module tb_decode_fwd;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush, stall_D;
  logic [3:0]  d_icode, d_ifun, d_ra, d_rb;
  logic [63:0] d_valc, d_valp;
  logic [63:0] rf [15];
  logic [3:0]  e_dste, mdste, mdstm, wdste, wdstm;
  logic [63:0] e_vale, mvale, mvalm, wvale, wvalm;
  logic [3:0]  E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
  logic [63:0] E_valC, E_valA, E_valB;

  int checks = 0;
  int failures = 0;
  logic obs_stall;

  // Per-icode role tables: bit i set means the rule applies to icode i.
  logic [15:0] srca_ra  = 16'h0454;
  logic [15:0] srca_rsp = 16'h0A00;
  logic [15:0] srcb_rb  = 16'h0070;
  logic [15:0] srcb_rsp = 16'h0F00;
  logic [15:0] dste_rb  = 16'h004C;
  logic [15:0] dste_rsp = 16'h0F00;
  logic [15:0] dstm_ra  = 16'h0820;
  logic [15:0] use_valp = 16'h0180;

  // Model of the E register contents.
  logic [3:0]  m_icode, m_ifun, m_dste, m_dstm, m_srca, m_srcb;
  logic [63:0] m_valc, m_vala, m_valb;

  decode_fwd dut (
    .clk(clk), .rst_n(rst_n),
    .D_icode(d_icode), .D_ifun(d_ifun), .D_ra(d_ra), .D_rb(d_rb),
    .D_valC(d_valc), .D_valP(d_valp), .flush(flush),
    .regis0(rf[0]), .regis1(rf[1]), .regis2(rf[2]), .regis3(rf[3]), .regis4(rf[4]),
    .regis5(rf[5]), .regis6(rf[6]), .regis7(rf[7]), .regis8(rf[8]), .regis9(rf[9]),
    .regis10(rf[10]), .regis11(rf[11]), .regis12(rf[12]), .regis13(rf[13]),
    .regis14(rf[14]),
    .e_dstE(e_dste), .e_valE(e_vale),
    .M_dstE(mdste), .M_dstM(mdstm), .M_valE(mvale), .m_valM(mvalm),
    .W_dstE(wdste), .W_dstM(wdstm), .W_valE(wvale), .W_valM(wvalm),
    .stall_D(stall_D),
    .E_icode(E_icode), .E_ifun(E_ifun), .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
    .E_dstE(E_dstE), .E_dstM(E_dstM), .E_srcA(E_srcA), .E_srcB(E_srcB)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] operand(input logic [3:0] src);
    logic [3:0]  dst [5];
    logic [63:0] val [5];
    dst = '{e_dste, mdstm, mdste, wdstm, wdste};
    val = '{e_vale, mvalm, mvale, wvalm, wvale};
`ifdef DECODE_FWD_EN
    for (int i = 0; i < 5; i++)
      if (dst[i] != 4'hF && dst[i] == src) return val[i];
`endif
    return (src == 4'hF) ? 64'd0 : rf[src];
  endfunction

  function automatic logic in_flight(input logic [3:0] src);
    logic [3:0] busy [6];
    busy = '{m_dste, m_dstm, mdste, mdstm, wdste, wdstm};
    if (src == 4'hF) return 1'b0;
    foreach (busy[i]) if (busy[i] == src) return 1'b1;
    return 1'b0;
  endfunction

  task automatic set_bubble();
    m_icode = 4'h1; m_ifun = 4'h0; m_valc = '0; m_vala = '0; m_valb = '0;
    m_dste = 4'hF; m_dstm = 4'hF; m_srca = 4'hF; m_srcb = 4'hF;
  endtask

  // Apply the current inputs for one cycle and compare stall_D and the new E contents.
  task automatic step();
    logic [3:0]  sa, sb, de, dm;
    logic [63:0] va, vb;
    logic        haz;
    #1;
    sa = srca_ra[d_icode] ? d_ra : (srca_rsp[d_icode] ? 4'h4 : 4'hF);
    sb = srcb_rb[d_icode] ? d_rb : (srcb_rsp[d_icode] ? 4'h4 : 4'hF);
    de = dste_rb[d_icode] ? d_rb : (dste_rsp[d_icode] ? 4'h4 : 4'hF);
    dm = dstm_ra[d_icode] ? d_ra : 4'hF;
    va = use_valp[d_icode] ? d_valp : operand(sa);
    vb = operand(sb);
`ifdef DECODE_FWD_EN
    haz = (m_icode == 4'h5 || m_icode == 4'hB) && m_dstm != 4'hF && (m_dstm == sa || m_dstm == sb);
`else
    haz = in_flight(sa) || in_flight(sb);
`endif
    obs_stall = stall_D;
    chk("stall_D", stall_D, {63'd0, haz && !flush});
    @(posedge clk);
    #1;
    if (!rst_n || haz || flush) set_bubble();
    else begin
      m_icode = d_icode; m_ifun = d_ifun; m_valc = d_valc; m_vala = va; m_valb = vb;
      m_dste = de; m_dstm = dm; m_srca = sa; m_srcb = sb;
    end
    chk("E_icode", E_icode, m_icode);
    chk("E_ifun",  E_ifun,  m_ifun);
    chk("E_valC",  E_valC,  m_valc);
    chk("E_valA",  E_valA,  m_vala);
    chk("E_valB",  E_valB,  m_valb);
    chk("E_dstE",  E_dstE,  m_dste);
    chk("E_dstM",  E_dstM,  m_dstm);
    chk("E_srcA",  E_srcA,  m_srca);
    chk("E_srcB",  E_srcB,  m_srcb);
  endtask

  task automatic idle();
    rst_n = 1'b1; flush = 1'b0;
    d_icode = 4'h1; d_ifun = 4'h0; d_ra = 4'hF; d_rb = 4'hF; d_valc = '0; d_valp = '0;
    e_dste = 4'hF; mdste = 4'hF; mdstm = 4'hF; wdste = 4'hF; wdstm = 4'hF;
  endtask

  function automatic logic [3:0] pick_reg();
    logic [3:0] pool [6];
    pool = '{4'h0, 4'h3, 4'h4, 4'h5, 4'hF, 4'hF};
    return ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : pool[$urandom_range(0, 5)];
  endfunction

  initial begin
    for (int i = 0; i < 15; i++) rf[i] = 64'h1000 + 64'(i);
    idle();
    // Reset with busy, non-hazarding inputs.
    rst_n = 1'b0; d_icode = 4'h6; d_ifun = 4'h3; d_ra = 4'h1; d_rb = 4'h2;
    d_valc = 64'hDEAD; d_valp = 64'hBEEF;
    e_dste = 4'h9; e_vale = 64'h77; mdste = 4'h7; mvale = 64'h1; mdstm = 4'h8; mvalm = 64'h2;
    wdste = 4'hA; wvale = 64'h3; wdstm = 4'hB; wvalm = 64'h4;
    repeat (2) @(posedge clk);
    #1;
    set_bubble();
    chk("rst_icode", E_icode, 64'h1);
    chk("rst_valA",  E_valA,  64'h0);
    chk("rst_valB",  E_valB,  64'h0);
    chk("rst_ids",   {E_dstE, E_dstM, E_srcA, E_srcB}, 64'hFFFF);
    chk("rst_stall", stall_D, 64'h0);

    // No hazard: addq %rbx,%rsp.
    idle(); rf[3] = 64'd5; rf[4] = 64'd9;
    d_icode = 4'h6; d_ra = 4'h3; d_rb = 4'h4;
    step();
    chk("nohaz_valA", E_valA, 64'd5);
    chk("nohaz_valB", E_valB, 64'd9);
    chk("nohaz_dstE", E_dstE, 64'h4);
    chk("nohaz_dstM", E_dstM, 64'hF);

    // Forwarding priority on srcA = 3.
    idle(); d_icode = 4'h2; d_ra = 4'h3; d_rb = 4'h1;
    e_dste = 4'h3; e_vale = 64'd11; mdste = 4'h3; mvale = 64'd22; wdste = 4'h3; wvale = 64'd33;
    step();
`ifdef DECODE_FWD_EN
    chk("prio_e", E_valA, 64'd11);
`else
    chk("prio_stall", obs_stall, 64'h1);
`endif
    e_dste = 4'hF;
    step();
`ifdef DECODE_FWD_EN
    chk("prio_m", E_valA, 64'd22);
`else
    chk("prio_stall2", obs_stall, 64'h1);
`endif

    // Load/use: mrmovq into %rax, then addq %rax,%rbx.
    idle(); d_icode = 4'h5; d_ra = 4'h0;
    step();
    d_icode = 4'h6; d_ra = 4'h0; d_rb = 4'h3;
    step();
    chk("lu_stall", obs_stall, 64'h1);
    chk("lu_nop", E_icode, 64'h1);
    mdstm = 4'h0; mvalm = 64'h77;
    step();
`ifdef DECODE_FWD_EN
    chk("lu_fwd", E_valA, 64'h77);
`endif

    // Flush in the hazard cycle drops the instruction.
    idle(); d_icode = 4'h5; d_ra = 4'h0;
    step();
    d_icode = 4'h6; d_ra = 4'h0; d_rb = 4'h3; flush = 1'b1;
    step();
    chk("fl_stall", obs_stall, 64'h0);
    chk("fl_nop", E_icode, 64'h1);

    // Reset during a stall clears it.
    idle(); d_icode = 4'h5; d_ra = 4'h0;
    step();
    d_icode = 4'h6; d_ra = 4'h0; d_rb = 4'h3; rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("rst_stall_gone", obs_stall, 64'h0);

    // call, then an addq depending on W_dstE.
    idle(); rf[4] = 64'h100; d_icode = 4'h8; d_valp = 64'h40; d_valc = 64'h200;
    step();
    chk("call_valA", E_valA, 64'h40);
    chk("call_valB", E_valB, 64'h100);
    chk("call_dstE", E_dstE, 64'h4);
    d_icode = 4'h6; d_ra = 4'h3; d_rb = 4'h5; wdste = 4'h3; wvale = 64'h55;
    step();
`ifdef DECODE_FWD_EN
    chk("w_fwd", E_valA, 64'h55);
`else
    chk("w_stall", obs_stall, 64'h1);
    wdste = 4'hF;
    step();
    chk("w_stall_end", obs_stall, 64'h0);
`endif

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      rst_n = ($urandom_range(0, 29) != 0);
      flush = ($urandom_range(0, 9) == 0);
      d_icode = 4'($urandom_range(0, 15)); d_ifun = 4'($urandom_range(0, 15));
      d_ra = pick_reg(); d_rb = pick_reg();
      d_valc = {$urandom, $urandom}; d_valp = {$urandom, $urandom};
      e_dste = pick_reg(); mdste = pick_reg(); mdstm = pick_reg();
      wdste = pick_reg(); wdstm = pick_reg();
      e_vale = {$urandom, $urandom}; mvale = {$urandom, $urandom};
      mvalm = {$urandom, $urandom}; wvale = {$urandom, $urandom}; wvalm = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) rf[$urandom_range(0, 14)] = {$urandom, $urandom};
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
